led7219_chain: RTL and testbench

//  Parametrised MAX7219 daisy-chain driver for the LED matrix panels: drives N_DEV

---
 rtl/led7219_chain.sv | 199 +++++++++++++++++++
 tb/tb_led7219_chain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led7219_chain.sv
// MAX7219 daisy-chain driver: init sequence, then continuous row refresh from a
// per-pass snapshot of the pixel bus, with intensity updates and periodic re-init.
module led7219_chain #(
   parameter int N_DEV         = 4,
   parameter int DIV_LOG2      = 5,
   parameter int SCAN_LIMIT    = 7,
   parameter int REINIT_PASSES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_DEV*64-1:0]  data,
   input  logic [3:0]           intensity,
   output logic                 leds_out,
   output logic                 leds_clk,
   output logic                 leds_cs,
   output logic                 pass_done
);

   localparam int FW   = 16 * N_DEV;
   localparam int NPER = FW + 5;
   localparam int BW   = $clog2(NPER);
   localparam int PW   = (REINIT_PASSES > 0) ? $clog2(REINIT_PASSES + 1) : 1;

   localparam logic [BW-1:0] LAST_PER  = BW'(NPER - 1);
   localparam logic [BW-1:0] FIRST_BIT = BW'(5);
   localparam logic [PW-1:0] PASS_WRAP = PW'(REINIT_PASSES);
   localparam logic [7:0]    SCAN_VAL  = 8'(SCAN_LIMIT);

   typedef enum logic [2:0] {
      INIT_SCAN = 3'd0,
      INIT_DEC  = 3'd1,
      INIT_INT  = 3'd2,
      INIT_SHDN = 3'd3,
      INIT_TEST = 3'd4,
      ROW       = 3'd5,
      INT_UPD   = 3'd6
   } state_t;

   logic [DIV_LOG2-1:0] div_q, div_d;
   logic [BW-1:0]       bit_q, bit_d;
   state_t              state_q, state_d;
   logic [2:0]          row_q, row_d;
   logic [PW-1:0]       pass_q, pass_d;
   logic [FW-1:0]       frame_q, frame_d;
   logic [N_DEV*64-1:0] shadow_q, shadow_d;
   logic [3:0]          int_shadow_q, int_shadow_d;
   logic [3:0]          int_sent_q, int_sent_d;
   logic                out_q, out_d;
   logic                sclk_q, sclk_d;
   logic                cs_q, cs_d;
   logic                done_q, done_d;

   logic                wrap_s;
   logic [BW-1:0]       nb_s;
   logic [7:0]          addr_s;
   logic [7:0]          val_s;
   logic [N_DEV*64-1:0] row_src_s;
   logic [FW-1:0]       built_s;

   // Frame contents for the current state; bit periods 0..4 of each slot are the CS-high gap.
   always_comb begin
      addr_s    = 8'h0F;
      val_s     = 8'h00;
      row_src_s = (row_q == 3'd0) ? data : shadow_q;
      case (state_q)
         INIT_SCAN: begin addr_s = 8'h0B; val_s = SCAN_VAL;                 end
         INIT_DEC:  begin addr_s = 8'h09; val_s = 8'h00;                    end
         INIT_INT:  begin addr_s = 8'h0A; val_s = {4'h0, intensity};        end
         INIT_SHDN: begin addr_s = 8'h0C; val_s = 8'h01;                    end
         INIT_TEST: begin addr_s = 8'h0F; val_s = 8'h00;                    end
         ROW:       begin addr_s = {5'b00000, row_q} + 8'd1; val_s = 8'h00; end
         INT_UPD:   begin addr_s = 8'h0A; val_s = {4'h0, int_shadow_q};     end
         default:   begin addr_s = 8'h0F; val_s = 8'h00;                    end
      endcase
      built_s = '0;
      for (int d = 0; d < N_DEV; d++) begin
         if (state_q == ROW) begin
            built_s[d*16 +: 16] = {addr_s, row_src_s[d*64 + int'(row_q)*8 +: 8]};
         end else begin
            built_s[d*16 +: 16] = {addr_s, val_s};
         end
      end
   end

   // Bit-period sequencing, frame shifting and state advance at each CS rise.
   always_comb begin
      div_d        = div_q + DIV_LOG2'(1);
      bit_d        = bit_q;
      state_d      = state_q;
      row_d        = row_q;
      pass_d       = pass_q;
      frame_d      = frame_q;
      shadow_d     = shadow_q;
      int_shadow_d = int_shadow_q;
      int_sent_d   = int_sent_q;
      out_d        = out_q;
      cs_d         = cs_q;
      done_d       = 1'b0;
      wrap_s       = (div_q == {DIV_LOG2{1'b1}});
      nb_s         = (bit_q == LAST_PER) ? '0 : bit_q + BW'(1);
      sclk_d       = div_d[DIV_LOG2-1] && (bit_q >= FIRST_BIT);

      if (wrap_s) begin
         bit_d = nb_s;
         if (nb_s == FIRST_BIT) begin
            cs_d    = 1'b0;
            out_d   = built_s[FW-1];
            frame_d = built_s << 1;
            if (state_q == INIT_INT) begin
               int_sent_d = intensity;
            end else if (state_q == INT_UPD) begin
               int_sent_d = int_shadow_q;
            end else if (state_q == ROW && row_q == 3'd0) begin
               shadow_d     = data;
               int_shadow_d = intensity;
            end else begin
               int_sent_d = int_sent_q;
            end
         end else if (nb_s > FIRST_BIT) begin
            cs_d    = 1'b0;
            out_d   = frame_q[FW-1];
            frame_d = frame_q << 1;
         end else begin
            cs_d  = 1'b1;
            out_d = 1'b1;
            if (nb_s == '0) begin
               case (state_q)
                  INIT_SCAN: state_d = INIT_DEC;
                  INIT_DEC:  state_d = INIT_INT;
                  INIT_INT:  state_d = INIT_SHDN;
                  INIT_SHDN: state_d = INIT_TEST;
                  INIT_TEST: begin state_d = ROW; row_d = 3'd0; end
                  INT_UPD:   begin state_d = ROW; row_d = 3'd0; end
                  ROW: begin
                     if (row_q != 3'd7) begin
                        row_d = row_q + 3'd1;
                     end else begin
                        done_d = 1'b1;
                        row_d  = 3'd0;
                        if (REINIT_PASSES != 0 && (pass_q + PW'(1)) == PASS_WRAP) begin
                           pass_d  = '0;
                           state_d = INIT_SCAN;
                        end else begin
                           // Counter only moves when periodic re-init is enabled.
                           pass_d  = (REINIT_PASSES != 0) ? pass_q + PW'(1) : pass_q;
                           state_d = (int_shadow_q != int_sent_q) ? INT_UPD : ROW;
                        end
                     end
                  end
                  default: begin state_d = INIT_SCAN; row_d = 3'd0; end
               endcase
            end else begin
               state_d = state_q;
            end
         end
      end else begin
         bit_d = bit_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q        <= '0;
         bit_q        <= '0;
         state_q      <= INIT_SCAN;
         row_q        <= 3'd0;
         pass_q       <= '0;
         frame_q      <= '0;
         shadow_q     <= '0;
         int_shadow_q <= 4'h0;
         int_sent_q   <= 4'h0;
         out_q        <= 1'b0;
         sclk_q       <= 1'b0;
         cs_q         <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         div_q        <= div_d;
         bit_q        <= bit_d;
         state_q      <= state_d;
         row_q        <= row_d;
         pass_q       <= pass_d;
         frame_q      <= frame_d;
         shadow_q     <= shadow_d;
         int_shadow_q <= int_shadow_d;
         int_sent_q   <= int_sent_d;
         out_q        <= out_d;
         sclk_q       <= sclk_d;
         cs_q         <= cs_d;
         done_q       <= done_d;
      end
   end

   assign leds_out  = out_q;
   assign leds_clk  = sclk_q;
   assign leds_cs   = cs_q;
   assign pass_done = done_q;

endmodule

// File: tb/tb_led7219_chain.sv
// Directed bench: decodes the serial stream of two 4-device chains (re-init every
// 16 and every 2 passes) into 64-bit frames and checks them against hand-built values.
module tb_led7219_chain;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] data;
   logic [3:0]   intensity;
   logic         out_a, clk_a, cs_a, done_a;
   logic         out_b, clk_b, cs_b, done_b;

   int total = 0;
   int passed = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led7219_chain #(.N_DEV(4), .DIV_LOG2(2), .SCAN_LIMIT(7), .REINIT_PASSES(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .data(data), .intensity(intensity),
      .leds_out(out_a), .leds_clk(clk_a), .leds_cs(cs_a), .pass_done(done_a));

   led7219_chain #(.N_DEV(4), .DIV_LOG2(2), .SCAN_LIMIT(7), .REINIT_PASSES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .data(data), .intensity(intensity),
      .leds_out(out_b), .leds_clk(clk_b), .leds_cs(cs_b), .pass_done(done_b));

   // Chain A monitor: shift on leds_clk rise while CS low, latch on CS rise.
   logic [63:0] sh_a = 64'h0;
   logic [63:0] q_a[$];
   logic        pclk_a = 1'b0, pcs_a = 1'b1, pdone_a = 1'b0;
   int cnt_a = 0, drop_a = 0, last_rise_a = -1;
   int min_per_a = 1000, max_per_a = 0, hi_a = 0, min_gap_a = 1000;
   int done_cyc_a = 0, done_rise_a = 0, done_bad_a = 0;

   always @(negedge clk) begin
      if (clk_a === 1'b1 && pclk_a === 1'b0 && cs_a === 1'b0) begin
         sh_a  <= {sh_a[62:0], out_a};
         cnt_a <= cnt_a + 1;
         if (last_rise_a >= 0) begin
            if (cyc - last_rise_a < min_per_a) min_per_a <= cyc - last_rise_a;
            if (cyc - last_rise_a > max_per_a) max_per_a <= cyc - last_rise_a;
         end
         last_rise_a <= cyc;
      end
      if (cs_a === 1'b1 && pcs_a === 1'b0) begin
         if (cnt_a == 64) q_a.push_back(sh_a);
         else drop_a <= drop_a + 1;
         cnt_a       <= 0;
         last_rise_a <= -1;
      end
      if (cs_a === 1'b1) begin
         hi_a <= hi_a + 1;
      end else if (pcs_a === 1'b1) begin
         if (hi_a < min_gap_a) min_gap_a <= hi_a;
         hi_a <= 0;
      end
      if (done_a === 1'b1) done_cyc_a <= done_cyc_a + 1;
      if (done_a === 1'b1 && pdone_a === 1'b0) begin
         done_rise_a <= done_rise_a + 1;
         if (!(cs_a === 1'b1 && pcs_a === 1'b0)) done_bad_a <= done_bad_a + 1;
      end
      pclk_a  <= clk_a;
      pcs_a   <= cs_a;
      pdone_a <= done_a;
   end

   // Chain B monitor: frames and pass_done pulses only.
   logic [63:0] sh_b = 64'h0;
   logic [63:0] q_b[$];
   logic        pclk_b = 1'b0, pcs_b = 1'b1, pdone_b = 1'b0;
   int cnt_b = 0, done_rise_b = 0;

   always @(negedge clk) begin
      if (clk_b === 1'b1 && pclk_b === 1'b0 && cs_b === 1'b0) begin
         sh_b  <= {sh_b[62:0], out_b};
         cnt_b <= cnt_b + 1;
      end
      if (cs_b === 1'b1 && pcs_b === 1'b0) begin
         if (cnt_b == 64) q_b.push_back(sh_b);
         cnt_b <= 0;
      end
      if (done_b === 1'b1 && pdone_b === 1'b0) done_rise_b <= done_rise_b + 1;
      pclk_b  <= clk_b;
      pcs_b   <= cs_b;
      pdone_b <= done_b;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_a(input int n);
      int t = 0;
      while (q_a.size() < n && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("wait_a_frames", 64'(q_a.size() >= n), 64'd1);
   endtask

   task automatic wait_b(input int n);
      int t = 0;
      while (q_b.size() < n && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("wait_b_frames", 64'(q_b.size() >= n), 64'd1);
   endtask

   function automatic logic [63:0] init_exp(input int i, input logic [3:0] inten);
      logic [15:0] w;
      case (i)
         0:       w = 16'h0B07;
         1:       w = 16'h0900;
         2:       w = {8'h0A, 4'h0, inten};
         3:       w = 16'h0C01;
         default: w = 16'h0F00;
      endcase
      return {4{w}};
   endfunction

   // Device 3 word first, device 0 word last.
   function automatic logic [63:0] exp_row(input logic [255:0] dv, input int r);
      logic [63:0] res = 64'h0;
      for (int d = 0; d < 4; d++) res[d*16 +: 16] = {8'(r), dv[d*64 + (r-1)*8 +: 8]};
      return res;
   endfunction

   logic [255:0] d0, d1;
   logic [63:0]  f;
   int base, n0a;

   initial begin
      for (int d = 0; d < 4; d++)
         for (int r = 1; r <= 8; r++) d0[d*64 + (r-1)*8 +: 8] = 8'(d*16 + r);
      d0[0*64 + 2*8 +: 8] = 8'hA5;
      d0[3*64 + 2*8 +: 8] = 8'h3C;
      d1 = d0 ^ {32{8'h5A}};
      data      = d0;
      intensity = 4'd7;
      rst_n     = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cs",   64'(cs_a),   64'd1);
      chk("rst_clk",  64'(clk_a),  64'd0);
      chk("rst_out",  64'(out_a),  64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      rst_n = 1'b1;

      wait_a(5);
      for (int i = 0; i < 5; i++) chk($sformatf("init%0d", i), q_a[i], init_exp(i, 4'd7));

      wait_a(8);
      f = q_a[7];
      chk("row3_dev3", 64'(f[63:48]), 64'h033C);
      chk("row3_dev0", 64'(f[15:0]),  64'h03A5);
      chk("row3_full", f, exp_row(d0, 3));

      // Change pixels while row 4 of pass 2 is on the wire.
      wait_a(16);
      repeat (140) @(negedge clk);
      chk("mid_row4_cs", 64'(cs_a), 64'd0);
      data = d1;
      wait_a(29);
      for (int r = 4; r <= 8; r++) chk($sformatf("p2_row%0d_old", r), q_a[12+r], exp_row(d0, r));
      for (int r = 1; r <= 8; r++) chk($sformatf("p3_row%0d_new", r), q_a[20+r], exp_row(d1, r));

      wait_b(27);
      chk("b_p2_row8", q_b[20], exp_row(d0, 8));
      for (int i = 0; i < 5; i++) chk($sformatf("b_reinit%0d", i), q_b[21+i], init_exp(i, 4'd7));
      chk("b_row1_after_reinit", q_b[26], exp_row(d1, 1));
      chk("b_pass_done_cnt", 64'(done_rise_b), 64'd2);

      // Intensity change mid pass 4: picked up by pass 5 snapshot, one update frame after it.
      wait_a(31);
      repeat (100) @(negedge clk);
      intensity = 4'd2;
      wait_a(55);
      chk("p4_row8",  q_a[36], exp_row(d1, 8));
      chk("p5_row1",  q_a[37], exp_row(d1, 1));
      chk("p5_row8",  q_a[44], exp_row(d1, 8));
      chk("int_upd",  q_a[45], {4{16'h0A02}});
      chk("p6_row1",  q_a[46], exp_row(d1, 1));
      chk("p6_row8",  q_a[53], exp_row(d1, 8));
      chk("p7_row1",  q_a[54], exp_row(d1, 1));
      n0a = 0;
      for (int i = 29; i < 55; i++) begin
         f = q_a[i];
         if (f[63:56] == 8'h0A) n0a++;
      end
      chk("int_frames", 64'(n0a), 64'd1);
      chk("a_pass_done_cnt", 64'(done_rise_a), 64'd6);

      // Reset in the middle of a row frame.
      wait_a(56);
      repeat (100) @(negedge clk);
      chk("pre_rst_cs", 64'(cs_a), 64'd0);
      base  = q_a.size();
      rst_n = 1'b0;
      #1;
      chk("async_cs",  64'(cs_a),  64'd1);
      chk("async_clk", 64'(clk_a), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_a(base + 5);
      for (int i = 0; i < 5; i++) chk($sformatf("reinit%0d", i), q_a[base+i], init_exp(i, 4'd2));
      chk("dropped_frames", 64'(drop_a),    64'd1);
      chk("cs_gap_min",     64'(min_gap_a), 64'd20);
      chk("sclk_per_min",   64'(min_per_a), 64'd4);
      chk("sclk_per_max",   64'(max_per_a), 64'd4);
      chk("done_width",     64'(done_cyc_a), 64'(done_rise_a));
      chk("done_at_cs_rise", 64'(done_bad_a), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
